// File: rtl/burst_dcache.sv
// burst_dcache: direct-mapped write-back write-allocate data cache in front of BurstRAM
module burst_dcache #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_BITWIDTH = 32,
    parameter int LINE_IX_BITWIDTH = 4,
    parameter int WORD_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT = 4,
    localparam int RAM_DEPTH_BITWIDTH = ADDRESS_BITWIDTH - WORD_IX_IN_LINE_BITWIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic [ADDRESS_BITWIDTH-1:0]            address,
    input  logic [DATA_BITWIDTH/8-1:0]             write_enable,
    input  logic [DATA_BITWIDTH-1:0]               data_in,
    output logic [DATA_BITWIDTH-1:0]               data_out,
    output logic                                   data_ready,
    output logic                                   busy,
    output logic                                   br_cmd,
    output logic                                   br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_rd_data,
    input  logic                                   br_rd_data_valid,
    input  logic                                   br_busy
);
    localparam int TAG_W = RAM_DEPTH_BITWIDTH - LINE_IX_BITWIDTH;
    localparam int LINES = 2 ** LINE_IX_BITWIDTH;
    localparam int LINE_W = (2 ** WORD_IX_IN_LINE_BITWIDTH) * DATA_BITWIDTH;
    localparam int BYTES = DATA_BITWIDTH / 8;
    localparam int BW = RAM_BURST_DATA_BITWIDTH;
    localparam int CNT_W = RAM_BURST_DATA_COUNT > 1 ? $clog2(RAM_BURST_DATA_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    typedef enum logic [2:0] {IDLE, WB_WAIT, WB_SEND, RD_WAIT, RD_RECV, COMPLETE} state_t;

    state_t                      state;
    logic [LINE_W-1:0]           lines [LINES];
    logic [TAG_W-1:0]            tags [LINES];
    logic [LINES-1:0]            valid;
    logic [LINES-1:0]            dirty;
    logic [ADDRESS_BITWIDTH-1:0] req_addr;
    logic [BYTES-1:0]            req_we;
    logic [DATA_BITWIDTH-1:0]    req_din;
    logic [CNT_W-1:0]            cnt;

    // In IDLE the live request is serviced directly; in COMPLETE the latched one replays as a hit
    logic [ADDRESS_BITWIDTH-1:0]         cur_addr;
    logic [BYTES-1:0]                    cur_we;
    logic [DATA_BITWIDTH-1:0]            cur_din;
    logic [TAG_W-1:0]                    cur_tag;
    logic [LINE_IX_BITWIDTH-1:0]         cur_ix;
    logic [WORD_IX_IN_LINE_BITWIDTH-1:0] cur_wi;
    logic [TAG_W-1:0]                    req_tag;
    logic [LINE_IX_BITWIDTH-1:0]         req_ix;
    logic                                hit;
    logic                                hit_go;
    logic [DATA_BITWIDTH-1:0]            word;
    logic [DATA_BITWIDTH-1:0]            merged;

    assign cur_addr = state == IDLE ? address : req_addr;
    assign cur_we = state == IDLE ? write_enable : req_we;
    assign cur_din = state == IDLE ? data_in : req_din;
    assign cur_tag = cur_addr[ADDRESS_BITWIDTH-1 -: TAG_W];
    assign cur_ix = cur_addr[WORD_IX_IN_LINE_BITWIDTH +: LINE_IX_BITWIDTH];
    assign cur_wi = cur_addr[WORD_IX_IN_LINE_BITWIDTH-1:0];
    assign req_tag = req_addr[ADDRESS_BITWIDTH-1 -: TAG_W];
    assign req_ix = req_addr[WORD_IX_IN_LINE_BITWIDTH +: LINE_IX_BITWIDTH];
    assign hit = valid[cur_ix] && tags[cur_ix] == cur_tag;
    assign hit_go = state == IDLE && enable && hit;
    assign word = lines[cur_ix][cur_wi*DATA_BITWIDTH +: DATA_BITWIDTH];

    // Byte-enable merge of the write data over the addressed word
    always_comb begin
        merged = word;
        for (int b = 0; b < BYTES; b++)
            if (cur_we[b]) merged[b*8 +: 8] = cur_din[b*8 +: 8];
    end

    // Command strobes are gated by br_busy in the same cycle so a busy BurstRAM never sees one
    assign busy = state != IDLE;
    assign br_cmd = state == WB_WAIT;
    assign br_cmd_en = (state == WB_WAIT || state == RD_WAIT) && !br_busy;
    assign br_addr = state == WB_WAIT ? {tags[req_ix], req_ix} : state == RD_WAIT ? {req_tag, req_ix} : '0;
    assign br_wr_data = (state == WB_WAIT || state == WB_SEND) ? lines[req_ix][cnt*BW +: BW] : '0;
    assign br_data_mask = '0;

    // Line storage: refill beats, tag install on the last beat, byte merges on hit/complete
    always_ff @(posedge clk) begin
        if (!rst && state == RD_RECV && br_rd_data_valid) begin
            lines[req_ix][cnt*BW +: BW] <= br_rd_data;
            if (cnt == LAST) tags[req_ix] <= req_tag;
        end
        if (!rst && (hit_go || state == COMPLETE) && |cur_we)
            lines[cur_ix][cur_wi*DATA_BITWIDTH +: DATA_BITWIDTH] <= merged;
    end

    // Request sequencing: accept, victim write-back, refill, replay, with valid/dirty bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
            data_ready <= 1'b0;
            data_out <= '0;
            cnt <= '0;
            req_addr <= '0;
            req_we <= '0;
            req_din <= '0;
        end else begin
            data_ready <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    req_addr <= address;
                    req_we <= write_enable;
                    req_din <= data_in;
                    cnt <= '0;
                    if (hit) begin
                        data_ready <= 1'b1;
                        data_out <= merged;
                        if (|write_enable) dirty[cur_ix] <= 1'b1;
                    end else begin
                        state <= valid[cur_ix] && dirty[cur_ix] ? WB_WAIT : RD_WAIT;
                    end
                end
                WB_WAIT: if (!br_busy) begin
                    state <= WB_SEND;
                    cnt <= CNT_W'(1);
                end
                WB_SEND: begin
                    cnt <= cnt == LAST ? '0 : cnt + 1'b1;
                    if (cnt == LAST) state <= RD_WAIT;
                end
                RD_WAIT: if (!br_busy) begin
                    state <= RD_RECV;
                    cnt <= '0;
                end
                RD_RECV: if (br_rd_data_valid) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        valid[req_ix] <= 1'b1;
                        dirty[req_ix] <= 1'b0;
                        state <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    data_ready <= 1'b1;
                    data_out <= merged;
                    if (|req_we) dirty[req_ix] <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_dcache.sv
// tb_burst_dcache: randomized self-checking bench for burst_dcache against a flat-memory reference model
module tb_burst_dcache;
    logic        clk = 0;
    logic        rst = 1;
    logic        enable = 0;
    logic [31:0] address = 0;
    logic [3:0]  write_enable = 0;
    logic [31:0] data_in = 0;
    logic [31:0] data_out;
    logic        data_ready, busy, br_cmd, br_cmd_en;
    logic [28:0] br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data = 0;
    logic        br_rd_data_valid = 0;
    logic        br_busy = 0;

    burst_dcache dut (
        .clk(clk), .rst(rst), .enable(enable), .address(address), .write_enable(write_enable),
        .data_in(data_in), .data_out(data_out), .data_ready(data_ready), .busy(busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // External memory (what BurstRAM really holds) and the CPU-visible memory the cache must present
    logic [31:0] ram [logic [31:0]];
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return ((a >> 3) << 7) | (a & 32'd7);
    endfunction
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction
    function automatic logic [31:0] model_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    // Direct-mapped presence model: which tag each index holds and whether it is modified
    bit          cval [16];
    bit          cdirty [16];
    logic [24:0] ctag [16];

    int          n_rd = 0, n_wr = 0, n_dr = 0, dr_exp = 0;
    int          rd_wait = 0, rd_left = 0, wb_left = 0;
    logic [28:0] rd_line, wb_line;
    logic [28:0] last_rd_addr = 0, last_wr_addr = 0;
    logic [63:0] last_wb_beat0 = 0;
    bit          force_busy = 0, rand_busy = 1, gaps = 1;

    task automatic wb_beat(input logic [28:0] line, input int k, input logic [63:0] beat);
        logic [31:0] a;
        a = {line, 3'(2 * k)};
        chk("wb_beat_lo", 64'(beat[31:0]), 64'(model_word(a)));
        chk("wb_beat_hi", 64'(beat[63:32]), 64'(model_word(a + 1)));
        ram[a] = beat[31:0];
        ram[a + 1] = beat[63:32];
    endtask

    // BurstRAM model (read latency 5, random gaps/busy) plus per-cycle protocol monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_left = 0;
                rd_wait = 0;
                wb_left = 0;
            end else begin
                if (wb_left > 0) begin
                    wb_beat(wb_line, 4 - wb_left, br_wr_data);
                    wb_left--;
                end
                if (br_cmd_en) begin
                    chk("cmd_while_br_busy", 64'(br_busy), 64'(0));
                    chk("data_mask", 64'(br_data_mask), 64'(0));
                    if (br_cmd) begin
                        n_wr++;
                        last_wr_addr = br_addr;
                        wb_line = br_addr;
                        last_wb_beat0 = br_wr_data;
                        wb_beat(br_addr, 0, br_wr_data);
                        wb_left = 3;
                    end else begin
                        n_rd++;
                        last_rd_addr = br_addr;
                        rd_line = br_addr;
                        rd_wait = 5;
                        rd_left = 4;
                    end
                end
                if (data_ready) begin
                    n_dr++;
                    chk("ready_while_busy", 64'(busy), 64'(0));
                end
            end
            @(posedge clk);
            #1;
            br_busy = force_busy || (rand_busy && $urandom_range(3) == 0);
            if (rd_wait > 0) rd_wait--;
            br_rd_data_valid = rd_wait == 0 && rd_left > 0 && !(gaps && $urandom_range(2) == 0);
            if (br_rd_data_valid) begin
                br_rd_data = {ram_word({rd_line, 3'(2 * (4 - rd_left) + 1)}), ram_word({rd_line, 3'(2 * (4 - rd_left))})};
                rd_left--;
            end else begin
                br_rd_data = {$urandom, $urandom};
            end
        end
    end

    // One request, issued at a negedge; returns at the negedge where data_ready is seen
    task automatic req(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d, input int hold,
                       output logic [31:0] got);
        logic [3:0]  ix;
        logic [24:0] tg;
        logic [28:0] victim;
        logic [31:0] exp;
        bit          hit, wb, done;
        int          r0, w0, n;
        ix = a[6:3];
        tg = a[31:7];
        hit = cval[ix] && ctag[ix] == tg;
        wb = !hit && cval[ix] && cdirty[ix];
        victim = {ctag[ix], ix};
        exp = model_word(a);
        for (int b = 0; b < 4; b++) if (we[b]) exp[b*8 +: 8] = d[b*8 +: 8];
        r0 = n_rd;
        w0 = n_wr;
        force_busy = hold > 0;
        enable = 1;
        address = a;
        write_enable = we;
        data_in = d;
        @(posedge clk);
        #1;
        enable = 0;
        address = $urandom;
        write_enable = 4'($urandom);
        data_in = $urandom;
        n = 0;
        done = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
            force_busy = n < hold;
            if (hold > 0 && n == hold) begin
                chk("held_rd_cmds", 64'(n_rd - r0), 64'(0));
                chk("held_wr_cmds", 64'(n_wr - w0), 64'(0));
            end
            if (data_ready) done = 1;
            else if (busy && $urandom_range(3) == 0) begin
                enable = 1;
                address = $urandom;
                write_enable = 4'($urandom);
                data_in = $urandom;
                @(posedge clk);
                #1;
                enable = 0;
            end
        end
        force_busy = 0;
        chk("ready_seen", 64'(done), 64'(1));
        chk("data_out", 64'(data_out), 64'(exp));
        got = data_out;
        if (hit) begin
            chk("hit_latency", 64'(n), 64'(1));
            chk("hit_rd_cmds", 64'(n_rd - r0), 64'(0));
            chk("hit_wr_cmds", 64'(n_wr - w0), 64'(0));
        end else begin
            chk("miss_rd_cmds", 64'(n_rd - r0), 64'(1));
            chk("miss_rd_addr", 64'(last_rd_addr), 64'(a[31:3]));
            chk("miss_wr_cmds", 64'(n_wr - w0), 64'(wb));
            if (wb) chk("wb_addr", 64'(last_wr_addr), 64'(victim));
        end
        dr_exp++;
        if (we != 0) mem[a] = exp;
        cdirty[ix] = (hit && cdirty[ix]) || we != 0;
        cval[ix] = 1;
        ctag[ix] = tg;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_data_out"}, 64'(data_out), 64'(0));
        chk({tag, "_data_ready"}, 64'(data_ready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_br_cmd"}, 64'(br_cmd), 64'(0));
        chk({tag, "_br_cmd_en"}, 64'(br_cmd_en), 64'(0));
        chk({tag, "_br_addr"}, 64'(br_addr), 64'(0));
        chk({tag, "_br_wr_data"}, br_wr_data, 64'(0));
        chk({tag, "_br_data_mask"}, 64'(br_data_mask), 64'(0));
    endtask

    initial begin
        logic [31:0] got, a;
        logic [3:0]  we;
        int          n, hold;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 0;

        req(32'h010, 4'h0, 32'h0, 0, got);
        chk("t1_cold_data", 64'(got), 64'h100);
        chk("t1_rd_addr", 64'(last_rd_addr), 64'h002);
        req(32'h013, 4'h0, 32'h0, 0, got);
        chk("t1_hit_data", 64'(got), 64'h103);

        req(32'h011, 4'hF, 32'h11223344, 0, got);
        req(32'h011, 4'b0011, 32'hAAAABBBB, 0, got);
        chk("t2_merge_dout", 64'(got), 64'h1122BBBB);
        req(32'h011, 4'h0, 32'h0, 0, got);
        chk("t2_read_back", 64'(got), 64'h1122BBBB);

        req(32'h090, 4'h0, 32'h0, 0, got);
        chk("t3_wb_addr", 64'(last_wr_addr), 64'h002);
        chk("t3_wb_beat0", last_wb_beat0, 64'h1122BBBB_00000100);
        chk("t3_rd_addr", 64'(last_rd_addr), 64'h012);
        chk("t3_data", 64'(got), 64'h900);

        req(32'h200, 4'hF, 32'hDEADBEEF, 0, got);
        req(32'h200, 4'h0, 32'h0, 0, got);
        chk("t4_read_back", 64'(got), 64'hDEADBEEF);
        req(32'h600, 4'h0, 32'h0, 0, got);
        chk("t4_wb_addr", 64'(last_wr_addr), 64'h040);
        chk("t4_evict_data", 64'(got), 64'h6000);
        req(32'h200, 4'h0, 32'h0, 0, got);
        chk("t4_from_ram", 64'(got), 64'hDEADBEEF);

        req(32'h1234, 4'h0, 32'h0, 20, got);
        chk("t6_held_data", 64'(got), 64'h12304);

        enable = 1;
        address = 32'h3000;
        write_enable = 0;
        @(posedge clk);
        #1;
        enable = 0;
        n = 0;
        while (!br_rd_data_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_recv", 64'(br_rd_data_valid), 64'(1));
        rst = 1;
        @(negedge clk);
        chk_zero_outputs("midrst");
        @(negedge clk);
        rst = 0;
        foreach (cval[i]) begin
            cval[i] = 0;
            cdirty[i] = 0;
        end
        mem = ram;
        req(32'h3000, 4'h0, 32'h0, 0, got);
        chk("t6_reread_data", 64'(got), 64'h30000);

        repeat (300) begin
            a = 32'(($urandom_range(3) << 7) | $urandom_range(127));
            we = $urandom_range(1) ? 4'h0 : 4'($urandom);
            hold = $urandom_range(15) == 0 ? $urandom_range(25, 1) : 0;
            req(a, we, $urandom, hold, got);
        end

        repeat (3) @(negedge clk);
        chk("ready_pulse_total", 64'(n_dr), 64'(dr_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
